// File: rtl/rf_serial_ctrl.sv
// Bit-serial command controller owning a 2**ADDR_W x DATA_W register file.
// Optional CLEAR sweep (opcode 11) is built only when RF_CLEAR_EN is defined.
module rf_serial_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic sin,
  input  logic sin_valid,
  input  logic abort,
  output logic sout,
  output logic sout_valid,
  output logic busy,
  output logic done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CW    = $clog2((DATA_W > DEPTH) ? DATA_W : DEPTH);

  typedef enum logic [2:0] {IDLE, OPC, ADDR, RD, SHOUT, WDATA, WR, CLR} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          op_q, op_d;
  logic                done_q, done_d;
  logic                done_c;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   rf [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      addr_q  <= '0;
      op_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end

  // Storage is deliberately not reset; writes are gated by the FSM only.
  always_ff @(posedge clk) begin
    if (we) rf[waddr] <= wdata;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    addr_d  = addr_q;
    op_d    = op_q;
    done_d  = 1'b0;
    done_c  = 1'b0;
    we      = 1'b0;
    waddr   = addr_q;
    wdata   = sh_q;
    case (state_q)
      IDLE: if (sin_valid && !abort) begin
        op_d    = {sin, 1'b0};
        state_d = OPC;
      end
      OPC: if (sin_valid) begin
        op_d  = {op_q[1], sin};
        cnt_d = '0;
        case ({op_q[1], sin})
          2'b01, 2'b10: state_d = ADDR;
`ifdef RF_CLEAR_EN
          2'b11:        state_d = CLR;
`endif
          default: begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        endcase
      end
      ADDR: if (sin_valid) begin
        addr_d = {addr_q[ADDR_W-2:0], sin};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(ADDR_W-1)) begin
          cnt_d   = '0;
          state_d = (op_q == 2'b01) ? RD : WDATA;
        end
      end
      RD: begin
        sh_d    = rf[addr_q];
        cnt_d   = '0;
        state_d = SHOUT;
      end
      SHOUT: begin
        sh_d  = {sh_q[DATA_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_W-1)) begin
          done_c  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      WDATA: if (sin_valid) begin
        sh_d  = {sh_q[DATA_W-2:0], sin};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_W-1)) begin
          cnt_d   = '0;
          state_d = WR;
        end
      end
      WR: begin
        we      = 1'b1;
        done_c  = 1'b1;
        state_d = IDLE;
      end
`ifdef RF_CLEAR_EN
      CLR: begin
        we    = 1'b1;
        waddr = cnt_q[ADDR_W-1:0];
        wdata = '0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DEPTH-1)) begin
          done_c  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // Abort wins over everything in flight, including the WR commit.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      we      = 1'b0;
      done_c  = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign sout_valid = (state_q == SHOUT);
  assign sout       = sout_valid & sh_q[DATA_W-1];
  assign busy       = (state_q != IDLE);
  assign done       = done_q | done_c;

endmodule

// File: tb/tb_rf_serial_ctrl.sv
// Directed bench for rf_serial_ctrl: serial write/read, gaps, abort, reset, opcode 11.
module tb_rf_serial_ctrl;
  logic clk = 1'b0;
  logic rst, sin, sin_valid, abort;
  logic sout, sout_valid, busy, done;
  int   checks = 0;
  int   errors = 0;
  logic busy_ok;
  logic [63:0] rd;

  always #5 clk = ~clk;

  rf_serial_ctrl #(.DATA_W(64), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .abort(abort),
    .sout(sout), .sout_valid(sout_valid), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One valid bit, then `gap` idle cycles during which busy must stay high.
  task automatic bit_in(input logic b, input int gap);
    sin = b; sin_valid = 1'b1;
    @(negedge clk);
    sin = 1'b0; sin_valid = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic write_word(input logic [4:0] a, input logic [63:0] d,
                            input int gap, input logic abort_wr, input string tag);
    busy_ok = 1'b1;
    bit_in(1'b1, gap); bit_in(1'b0, gap);
    for (int i = 4; i >= 0; i--) bit_in(a[i], gap);
    for (int i = 63; i >= 0; i--) bit_in(d[i], (i == 0) ? 0 : gap + (i % 3));
    if (abort_wr) begin
      abort = 1'b1;
      #1 chk({tag, "_abort_done"}, done, 1'b0);
      @(negedge clk);
      abort = 1'b0;
    end else begin
      chk({tag, "_wr_done"}, done, 1'b1);
      @(negedge clk);
    end
    chk({tag, "_idle"}, busy, 1'b0);
    if (gap > 0) chk({tag, "_busy_in_gaps"}, busy_ok, 1'b1);
  endtask

  // stop_at >= 0 asserts rst asynchronously during that SHOUT cycle.
  task automatic read_word(input logic [4:0] a, output logic [63:0] data,
                           input int stop_at, input string tag);
    logic v_ok, d_ok;
    v_ok = 1'b1; d_ok = 1'b1; data = '0;
    bit_in(1'b0, 0); bit_in(1'b1, 0);
    for (int i = 4; i >= 0; i--) bit_in(a[i], 0);
    chk({tag, "_rd_cycle_valid"}, sout_valid, 1'b0);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == stop_at) begin
        #1 rst = 1'b1;
        #1 chk({tag, "_rst_sout_valid"}, sout_valid, 1'b0);
        chk({tag, "_rst_busy"}, busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (sout_valid !== 1'b1) v_ok = 1'b0;
      if (done !== (i == 63)) d_ok = 1'b0;
      data = {data[62:0], sout};
    end
    @(negedge clk);
    chk({tag, "_valid_run"}, v_ok, 1'b1);
    chk({tag, "_done_pos"}, d_ok, 1'b1);
    chk({tag, "_after_busy"}, busy, 1'b0);
    chk({tag, "_after_valid"}, sout_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_sout_valid", sout_valid, 1'b0);
    chk("reset_sout", sout, 1'b0);
    chk("reset_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    write_word(5'd5, 64'h0123456789ABCDEF, 0, 1'b0, "w5");
    read_word(5'd5, rd, -1, "r5");
    chk("r5_data", rd, 64'h0123456789ABCDEF);

    write_word(5'd9, 64'hDEADBEEFCAFEF00D, 1, 1'b0, "w9gap");
    read_word(5'd9, rd, -1, "r9");
    chk("r9_data", rd, 64'hDEADBEEFCAFEF00D);

    write_word(5'd31, 64'hFFFFFFFFFFFFFFFF, 0, 1'b0, "w31");
    write_word(5'd0, 64'h0, 0, 1'b0, "w0");
    read_word(5'd31, rd, -1, "r31");
    chk("r31_data", rd, 64'hFFFFFFFFFFFFFFFF);
    read_word(5'd0, rd, -1, "r0");
    chk("r0_data", rd, 64'h0);

    write_word(5'd3, 64'hAAAAAAAAAAAAAAAA, 0, 1'b0, "w3");
    write_word(5'd3, 64'h5555555555555555, 0, 1'b1, "w3ab");
    read_word(5'd3, rd, -1, "r3");
    chk("r3_data_after_abort", rd, 64'hAAAAAAAAAAAAAAAA);

    // Reset while sout carries bit 20 (the 44th shifted bit).
    read_word(5'd5, rd, 43, "r5rst");
    read_word(5'd5, rd, -1, "r5b");
    chk("r5_after_rst", rd, 64'h0123456789ABCDEF);

    abort = 1'b1; sin = 1'b1; sin_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0; sin = 1'b0; sin_valid = 1'b0;
    chk("idle_abort_busy", busy, 1'b0);

    bit_in(1'b0, 0); bit_in(1'b1, 0); bit_in(1'b1, 0);
    abort = 1'b1;
    #1 chk("addr_abort_done", done, 1'b0);
    @(negedge clk);
    abort = 1'b0;
    chk("addr_abort_busy", busy, 1'b0);
    chk("addr_abort_done2", done, 1'b0);
    read_word(5'd9, rd, -1, "r9b");
    chk("r9_after_abort", rd, 64'hDEADBEEFCAFEF00D);

    bit_in(1'b0, 0); bit_in(1'b0, 0);
    chk("nop_done", done, 1'b1);
    chk("nop_busy", busy, 1'b0);
    @(negedge clk);
    chk("nop_done_cleared", done, 1'b0);

    write_word(5'd7, 64'h5555555555555555, 0, 1'b0, "w7");
    bit_in(1'b1, 0); bit_in(1'b1, 0);
`ifdef RF_CLEAR_EN
    begin
      logic b_ok, d_ok;
      b_ok = 1'b1; d_ok = 1'b1;
      for (int i = 0; i < 32; i++) begin
        if (busy !== 1'b1) b_ok = 1'b0;
        if (done !== (i == 31)) d_ok = 1'b0;
        @(negedge clk);
      end
      chk("clr_busy_run", b_ok, 1'b1);
      chk("clr_done_pos", d_ok, 1'b1);
      chk("clr_idle", busy, 1'b0);
    end
    read_word(5'd7, rd, -1, "r7");
    chk("r7_cleared", rd, 64'h0);
    read_word(5'd31, rd, -1, "r31c");
    chk("r31_cleared", rd, 64'h0);
`else
    chk("op11_done", done, 1'b1);
    chk("op11_busy", busy, 1'b0);
    @(negedge clk);
    read_word(5'd7, rd, -1, "r7");
    chk("r7_kept", rd, 64'h5555555555555555);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_serial_ctrl.md
Name: rf_serial_ctrl

Overview:
- Serial command controller that owns a 32 x 64-bit register file and sequences all access to it over a one-bit pin interface.
- Shifts in an opcode, an address and optional write data, performs one RF read or write, and shifts read data back out MSB-first.
- Sits between the top-level pin wrapper and the RF storage. Replaces ad-hoc direct control of the RF from the pins.

Parameters:
- DATA_W, 64, RF word width in bits.
- ADDR_W, 5, RF address width; depth is 2**ADDR_W.

Ports:
- clk, input, 1, the single clock; all state updates on posedge clk.
- rst, input, 1, asynchronous active-high reset.
- sin, input, 1, serial command/data bit, MSB-first.
- sin_valid, input, 1, sin is sampled only in cycles where this is 1.
- abort, input, 1, synchronous command abort.
- sout, output, 1, serial read data, MSB-first.
- sout_valid, output, 1, sout carries a valid bit this cycle.
- busy, output, 1, high whenever state != IDLE.
- done, output, 1, one-cycle pulse on command completion.

Behaviour:
- Reset: asynchronous, active-high; state=IDLE, bit counter=0, shift register=0, sout=0, sout_valid=0, busy=0, done=0. RF contents are not reset. Reset mid-command drops the command with no RF write.
- Frame format: opcode[1:0], then addr[ADDR_W-1:0], then data[DATA_W-1:0] (WRITE only). All fields MSB-first; only sin_valid=1 cycles count. Gaps with sin_valid=0 are allowed anywhere in the input phases.
- Opcodes: 00 NOP, 01 READ, 10 WRITE, 11 CLEAR (see Optional Feature).
- States and transitions:
  - IDLE: leaves on the first valid bit; that bit is opcode[1].
  - OPC: collects opcode[0]. NOP returns to IDLE and pulses done in the cycle after the 2nd opcode bit. READ/WRITE go to ADDR.
  - ADDR: collects ADDR_W valid bits. READ goes to RD; WRITE goes to WDATA.
  - RD: one cycle; the shift register loads rf[addr]. Next state SHOUT.
  - SHOUT: exactly DATA_W consecutive cycles, independent of sin_valid.
    - sout = shift register MSB; sout_valid = 1; shift left by one per cycle.
    - done is asserted together with the last bit (bit 0); the following cycle is IDLE.
    - sin and sin_valid are ignored in this state.
  - WDATA: collects DATA_W valid bits, then goes to WR.
  - WR: one cycle; rf[addr] <= data at the end of this cycle; done=1 in this cycle; then IDLE.
- Read latency: if the last addr bit is sampled in cycle N, RD is in N+1, sout bit 63 is in N+2, bit 0 plus done is in N+65, and IDLE is in N+66.
- A WRITE completes before any following command's RD, so a read-after-write returns the new data.
- abort=1 in any non-IDLE state forces IDLE on the next edge.
  - No RF write occurs, including when abort coincides with WR.
  - sout_valid drops in the next cycle; done is not pulsed.
  - abort in IDLE has no effect; a valid sin bit in the same cycle is discarded.
- rst has priority over abort; abort has priority over every other transition.
- sout=0 whenever sout_valid=0.

Optional Feature:
- Macro: RF_CLEAR_EN.
- Defined: opcode 11 enters state CLR, which takes no address and no data.
  - CLR writes zero to rf[0], rf[1], ... rf[31], one address per cycle, over 32 cycles.
  - done is pulsed on the cycle that writes rf[31]; then IDLE.
  - abort during CLR stops the sweep immediately; addresses already cleared stay cleared.
- Not defined: opcode 11 behaves exactly like NOP, and no CLR logic is synthesised.

Test Plan:
- WRITE addr 5 data 0x0123456789ABCDEF, then READ addr 5 -> sout_valid high for 64 consecutive cycles; sout serialises 0x0123456789ABCDEF MSB-first; done coincides with the last bit.
- WRITE with sin_valid=0 gaps inserted between bits -> same RF result as the gap-free frame; busy stays high throughout.
- READ addr 31 after WRITE addr 31 = 0xFFFFFFFFFFFFFFFF, then WRITE addr 0 = 0 -> reading addr 31 returns all ones (no aliasing).
- WRITE addr 3 = 0xAA..AA, then a second WRITE to addr 3 with abort asserted in its WR cycle -> READ addr 3 returns 0xAA..AA; no done pulse on the aborted command.
- rst asserted during SHOUT at bit 20 -> sout_valid=0 and busy=0 immediately (asynchronously); a subsequent READ of the same address returns the full unchanged word.
- RF_CLEAR_EN defined: fill addr 7 = 0x55..55, send opcode 11 -> busy for 32 cycles, done on the 32nd, READ addr 7 = 0. Macro undefined: opcode 11 -> done in the cycle after the 2nd opcode bit, addr 7 still 0x55..55.
